// File: rtl/keypad_lock_ctrl.sv
// Parametrised keypad lock controller: digit-by-digit code check, programmable
// code register, failed-attempt lockout and auto-relock timers.
// Ports: clk/reset (async, active-high); keypad strobes digit_valid_i/digit_i,
// enter_i, cancel_i; relock_i, prog_req_i; registered status outputs locked_o,
// unlocked_o, lockout_o, fail_cnt_o, prog_done_o.
module keypad_lock_ctrl #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1024,
  parameter int RELOCK_CYC  = 4096,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          digit_valid_i,
  input  logic [DIGIT_W-1:0]            digit_i,
  input  logic                          enter_i,
  input  logic                          cancel_i,
  input  logic                          relock_i,
  input  logic                          prog_req_i,
  output logic                          locked_o,
  output logic                          unlocked_o,
  output logic                          lockout_o,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt_o,
  output logic                          prog_done_o
);

  localparam int CODE_W  = CODE_LEN * DIGIT_W;
  localparam int DC_W    = $clog2(CODE_LEN + 2);
  localparam int FC_W    = $clog2(MAX_FAIL + 1);
  localparam int TMR_MAX = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC : RELOCK_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   shadow_q, shadow_d;
  logic [DC_W-1:0]     dcnt_q, dcnt_d;
  logic                mism_q, mism_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [FC_W-1:0]     fail_q, fail_d;
  logic                prog_done_d;
  logic                locked_q, unlocked_q, lockout_q, prog_done_q;

  logic [DIGIT_W-1:0]  exp_digit;
  logic                dig_bad;
  logic [DC_W-1:0]     dcnt_inc;
  logic                entry_ok;
  logic                fail_last;

  // Expected digit at the current position, MS digit first. Positions at or
  // beyond CODE_LEN have no expected digit and always count as a mismatch.
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (dcnt_q == DC_W'(i)) begin
        exp_digit = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign dig_bad   = (dcnt_q >= DC_W'(CODE_LEN)) || (digit_i != exp_digit);
  // Saturate at CODE_LEN+1: enough to tell "too long" from "exact".
  assign dcnt_inc  = (dcnt_q == DC_W'(CODE_LEN + 1)) ? dcnt_q : dcnt_q + DC_W'(1);
  assign entry_ok  = (dcnt_q == DC_W'(CODE_LEN)) && !mism_q;
  assign fail_last = (32'(fail_q) + 32'd1 >= 32'(MAX_FAIL));

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    shadow_d    = shadow_q;
    dcnt_d      = dcnt_q;
    mism_d      = mism_q;
    tmr_d       = tmr_q;
    fail_d      = fail_q;
    prog_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A digit arriving with enter/cancel is dropped by strobe priority.
        if (digit_valid_i && !enter_i && !cancel_i) begin
          state_d = S_ENTRY;
          dcnt_d  = dcnt_inc;
          mism_d  = mism_q | dig_bad;
        end
      end

      S_ENTRY: begin
        if (cancel_i) begin
          state_d = S_IDLE;
          dcnt_d  = '0;
          mism_d  = 1'b0;
        end else if (enter_i) begin
          dcnt_d = '0;
          mism_d = 1'b0;
          if (entry_ok) begin
            state_d = S_OPEN;
            fail_d  = '0;
          end else if (fail_last) begin
            state_d = S_LOCKOUT;
            fail_d  = FC_W'(MAX_FAIL);
          end else begin
            state_d = S_IDLE;
            fail_d  = fail_q + FC_W'(1);
          end
        end else if (digit_valid_i) begin
          dcnt_d = dcnt_inc;
          mism_d = mism_q | dig_bad;
        end
      end

      S_OPEN: begin
        if (relock_i || (tmr_q == TMR_W'(RELOCK_CYC - 1))) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else if (prog_req_i) begin
          state_d  = S_PROG;
          tmr_d    = '0;
          dcnt_d   = '0;
          shadow_d = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_PROG: begin
        // Relock timer stays frozen here; it restarts from 0 back in OPEN.
        if (cancel_i || enter_i) begin
          if (!cancel_i && (dcnt_q == DC_W'(CODE_LEN))) begin
            code_d      = shadow_q;
            prog_done_d = 1'b1;
          end
          state_d = S_OPEN;
          dcnt_d  = '0;
          tmr_d   = '0;
        end else if (digit_valid_i) begin
          shadow_d = (shadow_q << DIGIT_W) | CODE_W'(digit_i);
          dcnt_d   = dcnt_inc;
        end
      end

      S_LOCKOUT: begin
        if (tmr_q == TMR_W'(LOCKOUT_CYC - 1)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        dcnt_d  = '0;
        mism_d  = 1'b0;
        tmr_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= '0;
      dcnt_q      <= '0;
      mism_q      <= 1'b0;
      tmr_q       <= '0;
      fail_q      <= '0;
      locked_q    <= 1'b1;
      unlocked_q  <= 1'b0;
      lockout_q   <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      shadow_q    <= shadow_d;
      dcnt_q      <= dcnt_d;
      mism_q      <= mism_d;
      tmr_q       <= tmr_d;
      fail_q      <= fail_d;
      locked_q    <= !((state_d == S_OPEN) || (state_d == S_PROG));
      unlocked_q  <= (state_d == S_OPEN) || (state_d == S_PROG);
      lockout_q   <= (state_d == S_LOCKOUT);
      prog_done_q <= prog_done_d;
    end
  end

  assign locked_o    = locked_q;
  assign unlocked_o  = unlocked_q;
  assign lockout_o   = lockout_q;
  assign fail_cnt_o  = fail_q;
  assign prog_done_o = prog_done_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl with default parameters: directed scenarios plus a
// randomized run, all checked against a behavioural model built from digit
// queues and a remaining-cycles counter.
module tb_keypad_lock_ctrl;

  localparam int RCYC = 4096;
  localparam int LCYC = 1024;
  localparam int MAXF = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       digit_valid_i = 1'b0;
  logic [3:0] digit_i = '0;
  logic       enter_i = 1'b0, cancel_i = 1'b0, relock_i = 1'b0, prog_req_i = 1'b0;
  logic       locked_o, unlocked_o, lockout_o, prog_done_o;
  logic [1:0] fail_cnt_o;
  logic [5:0] dut_vec;

  int n_chk = 0;
  int n_bad = 0;

  // Model: 0 idle, 1 entry, 2 open, 3 prog, 4 lockout
  int m_mode;
  int m_entry[$];
  int m_shadow[$];
  int m_code[4];
  int m_fail;
  int m_left;
  bit m_pd;

  keypad_lock_ctrl dut (
    .clk(clk), .reset(reset),
    .digit_valid_i(digit_valid_i), .digit_i(digit_i),
    .enter_i(enter_i), .cancel_i(cancel_i),
    .relock_i(relock_i), .prog_req_i(prog_req_i),
    .locked_o(locked_o), .unlocked_o(unlocked_o), .lockout_o(lockout_o),
    .fail_cnt_o(fail_cnt_o), .prog_done_o(prog_done_o)
  );

  always #5 clk = ~clk;

  assign dut_vec = {locked_o, unlocked_o, lockout_o, fail_cnt_o, prog_done_o};

  function automatic logic [5:0] exp_vec();
    logic lk;
    lk = !(m_mode == 2 || m_mode == 3);
    return {lk, !lk, (m_mode == 4), 2'(m_fail), m_pd};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fail = 0; m_left = 0; m_pd = 0;
    m_entry.delete(); m_shadow.delete();
    m_code[0] = 1; m_code[1] = 2; m_code[2] = 3; m_code[3] = 4;
  endtask

  task automatic model_step(input bit dv, input int d, input bit en, input bit ca,
                            input bit rl, input bit pr);
    bit pass;
    m_pd = 0;
    case (m_mode)
      0: if (dv && !en && !ca) begin m_entry.delete(); m_entry.push_back(d); m_mode = 1; end
      1: begin
        if (ca) begin
          m_entry.delete(); m_mode = 0;
        end else if (en) begin
          pass = (m_entry.size() == 4);
          if (pass) for (int i = 0; i < 4; i++) if (m_entry[i] != m_code[i]) pass = 0;
          m_entry.delete();
          if (pass) begin m_mode = 2; m_left = RCYC; m_fail = 0; end
          else begin
            m_fail++;
            if (m_fail >= MAXF) begin m_mode = 4; m_left = LCYC; end
            else m_mode = 0;
          end
        end else if (dv) m_entry.push_back(d);
      end
      2: begin
        if (rl || m_left == 1) m_mode = 0;
        else if (pr) begin m_mode = 3; m_shadow.delete(); end
        else m_left--;
      end
      3: begin
        if (ca || en) begin
          if (!ca && m_shadow.size() == 4) begin
            for (int i = 0; i < 4; i++) m_code[i] = m_shadow[i];
            m_pd = 1;
          end
          m_mode = 2; m_left = RCYC;
        end else if (dv) m_shadow.push_back(d);
      end
      4: begin
        if (m_left == 1) begin m_mode = 0; m_fail = 0; end
        else m_left--;
      end
      default: m_mode = 0;
    endcase
  endtask

  // Drive one cycle of strobes, advance the model at the edge, sample at +1.
  task automatic step(input bit dv, input int d, input bit en, input bit ca,
                      input bit rl, input bit pr);
    digit_valid_i = dv; digit_i = 4'(d); enter_i = en; cancel_i = ca;
    relock_i = rl; prog_req_i = pr;
    @(posedge clk);
    model_step(dv, d, en, ca, rl, pr);
    #1;
    digit_valid_i = 0; enter_i = 0; cancel_i = 0; relock_i = 0; prog_req_i = 0;
  endtask

  task automatic press(input int d);   step(1, d, 0, 0, 0, 0); endtask
  task automatic idle();               step(0, 0, 0, 0, 0, 0); endtask
  task automatic do_enter();           step(0, 0, 1, 0, 0, 0); endtask
  task automatic do_relock();          step(0, 0, 0, 0, 1, 0); endtask
  task automatic seq4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic apply_reset();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (dut_vec !== 6'b100000) begin
      n_bad++; $display("FAIL reset_state got=%b exp=%b", dut_vec, 6'b100000);
    end
  endtask

  task automatic test_unlock();
    press(1); press(2); press(3);
    n_chk++;
    if (unlocked_o !== 1'b0) begin n_bad++; $display("FAIL unlock_early got=%b exp=0", unlocked_o); end
    press(4); do_enter();
    n_chk++;
    if (unlocked_o !== 1'b1 || fail_cnt_o !== 2'd0) begin
      n_bad++; $display("FAIL unlock_open got=%b/%0d exp=1/0", unlocked_o, fail_cnt_o);
    end
    for (int k = 1; k < RCYC; k++) begin
      idle();
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL open_hold cyc=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
    n_chk++;
    if (unlocked_o !== 1'b1) begin n_bad++; $display("FAIL open_last got=%b exp=1", unlocked_o); end
    idle();
    n_chk++;
    if (locked_o !== 1'b1) begin n_bad++; $display("FAIL auto_relock got=%b exp=1", locked_o); end
  endtask

  task automatic test_lockout();
    for (int a = 1; a <= 3; a++) begin
      seq4(1, 2, 3, 5); do_enter();
      n_chk++;
      if (a < 3 && (fail_cnt_o !== 2'(a) || lockout_o !== 1'b0)) begin
        n_bad++; $display("FAIL fail_step%0d got=%0d/%b exp=%0d/0", a, fail_cnt_o, lockout_o, a);
      end else if (a == 3 && (lockout_o !== 1'b1 || fail_cnt_o !== 2'd3)) begin
        n_bad++; $display("FAIL lockout_enter got=%b/%0d exp=1/3", lockout_o, fail_cnt_o);
      end
    end
    // Keypad activity (including the right code) must be ignored throughout.
    for (int k = 1; k < LCYC; k++) begin
      step($urandom_range(0, 1), (k % 4) + 1, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0), 1'b0, 1'b0);
      n_chk++;
      if (lockout_o !== 1'b1 || dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL lockout_hold cyc=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
    idle();
    n_chk++;
    if (lockout_o !== 1'b0 || fail_cnt_o !== 2'd0 || locked_o !== 1'b1) begin
      n_bad++; $display("FAIL lockout_exit got=%b exp=100000", dut_vec);
    end
  endtask

  task automatic test_length();
    seq4(1, 2, 3, 4); press(4); do_enter();
    n_chk++;
    if (fail_cnt_o !== 2'd1 || locked_o !== 1'b1) begin
      n_bad++; $display("FAIL too_long got=%0d/%b exp=1/1", fail_cnt_o, locked_o);
    end
    press(1); press(2); press(3); do_enter();
    n_chk++;
    if (fail_cnt_o !== 2'd2 || locked_o !== 1'b1) begin
      n_bad++; $display("FAIL too_short got=%0d/%b exp=2/1", fail_cnt_o, locked_o);
    end
    seq4(1, 2, 3, 4); do_enter();
    n_chk++;
    if (unlocked_o !== 1'b1 || fail_cnt_o !== 2'd0) begin
      n_bad++; $display("FAIL len_recover got=%b/%0d exp=1/0", unlocked_o, fail_cnt_o);
    end
    do_relock();
    n_chk++;
    if (locked_o !== 1'b1) begin n_bad++; $display("FAIL manual_relock got=%b exp=1", locked_o); end
  endtask

  task automatic test_prog();
    seq4(1, 2, 3, 4); do_enter();
    step(0, 0, 0, 0, 0, 1);
    seq4(9, 8, 7, 6); do_enter();
    n_chk++;
    if (prog_done_o !== 1'b1 || unlocked_o !== 1'b1) begin
      n_bad++; $display("FAIL prog_done_pulse got=%b/%b exp=1/1", prog_done_o, unlocked_o);
    end
    idle();
    n_chk++;
    if (prog_done_o !== 1'b0) begin n_bad++; $display("FAIL prog_done_width got=%b exp=0", prog_done_o); end
    do_relock();
    seq4(1, 2, 3, 4); do_enter();
    n_chk++;
    if (locked_o !== 1'b1 || fail_cnt_o !== 2'd1) begin
      n_bad++; $display("FAIL old_code got=%b/%0d exp=1/1", locked_o, fail_cnt_o);
    end
    seq4(9, 8, 7, 6); do_enter();
    n_chk++;
    if (unlocked_o !== 1'b1 || fail_cnt_o !== 2'd0) begin
      n_bad++; $display("FAIL new_code got=%b/%0d exp=1/0", unlocked_o, fail_cnt_o);
    end
    apply_reset();
    seq4(1, 2, 3, 4); do_enter();
    n_chk++;
    if (unlocked_o !== 1'b1) begin n_bad++; $display("FAIL code_after_reset got=%b exp=1", unlocked_o); end
    do_relock();
  endtask

  task automatic test_collide();
    press(1); press(2); press(3);
    step(1, 4, 1, 0, 0, 0);
    n_chk++;
    if (fail_cnt_o !== 2'd1 || locked_o !== 1'b1) begin
      n_bad++; $display("FAIL digit_enter got=%0d/%b exp=1/1", fail_cnt_o, locked_o);
    end
    press(1); press(2);
    step(0, 0, 1, 1, 0, 0);
    n_chk++;
    if (fail_cnt_o !== 2'd1 || dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL cancel_enter got=%b exp=%b", dut_vec, exp_vec());
    end
    seq4(1, 2, 3, 4); do_enter();
    n_chk++;
    if (unlocked_o !== 1'b1 || fail_cnt_o !== 2'd0) begin
      n_bad++; $display("FAIL after_cancel got=%b/%0d exp=1/0", unlocked_o, fail_cnt_o);
    end
    do_relock();
  endtask

  task automatic test_reset_prog();
    seq4(1, 2, 3, 4); do_enter();
    step(0, 0, 0, 0, 0, 1);
    press(5); press(6);
    #2 reset = 1;
    #1;
    n_chk++;
    if (dut_vec !== 6'b100000) begin
      n_bad++; $display("FAIL async_reset got=%b exp=%b", dut_vec, 6'b100000);
    end
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    seq4(1, 2, 3, 4); do_enter();
    n_chk++;
    if (unlocked_o !== 1'b1) begin n_bad++; $display("FAIL default_code_back got=%b exp=1", unlocked_o); end
    do_relock();
  endtask

  task automatic test_random();
    int d;
    apply_reset();
    for (int k = 0; k < 4000; k++) begin
      if ((m_mode <= 1) && (m_entry.size() < 4) && ($urandom_range(0, 99) < 80))
        d = m_code[m_entry.size()];
      else
        d = $urandom_range(0, 15);
      step(($urandom_range(0, 99) < 55), d, ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 6));
      n_chk++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random cyc=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_unlock();
    test_lockout();
    test_length();
    test_prog();
    test_collide();
    test_reset_prog();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
